// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Little-endian byte enables for an already-legal (aligned) access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << off;
      HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_mem_bank.sv
// DEPTH x 32 word storage: byte-enable synchronous write, asynchronous word read.
module ahb_mem_bank #(
  parameter int unsigned DEPTH = 256,
  parameter int          IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address-phase capture, legality check, wait-state
// stretching and the two-cycle ERROR response in front of ahb_mem_bank.
//   state   | meaning
//   IDLE    | no data phase, or zero-wait legal data phase completing now
//   WAIT    | legal data phase stretched; completes when r_cnt reaches 0
//   ERR1    | first ERROR cycle (hreadyout=0, hresp=1)
//   ERR2    | second ERROR cycle (hreadyout=1, hresp=1)
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              i_hclk,
  input  logic              i_hresetn,
  input  logic              i_hsel,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [31:0]       i_hwdata,
  input  logic              i_hready,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [31:0]       o_hrdata
);

  localparam int IDX_W = $clog2(DEPTH);

  slv_state_e        r_state;
  logic [3:0]        r_cnt;
  logic              r_active;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;

  logic              w_accept;
  logic              w_legal;
  logic              w_we;
  logic [3:0]        w_be;
  logic [31:0]       w_rdata;

  assign w_accept = i_hsel && i_hready &&
                    (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);

  always_comb begin
    w_legal = 1'b1;
    case (i_hsize)
      HSIZE_BYTE: w_legal = 1'b1;
      HSIZE_HALF: if (i_haddr[0]) w_legal = 1'b0;
      HSIZE_WORD: if (i_haddr[1:0] != 2'b00) w_legal = 1'b0;
      default:    w_legal = 1'b0;
    endcase
    if (32'(i_haddr >> 2) >= DEPTH) w_legal = 1'b0;
  end

  // r_active marks a legal data phase; error phases never touch memory.
  assign w_we     = r_active && r_write && o_hreadyout;
  assign w_be     = lane_mask(r_size, r_addr[1:0]);
  assign o_hrdata = (r_active && !r_write && o_hreadyout) ? w_rdata : 32'd0;

  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_active    <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= 3'd0;
      o_hreadyout <= 1'b1;
      o_hresp     <= HRESP_OKAY;
    end else if (o_hreadyout) begin
      // Any completing (or empty) cycle may take the next address phase.
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
      o_hresp  <= HRESP_OKAY;
      if (w_accept) begin
        r_write <= i_hwrite;
        r_addr  <= i_haddr;
        r_size  <= i_hsize;
        if (!w_legal) begin
          r_state     <= ST_ERR1;
          o_hreadyout <= 1'b0;
          o_hresp     <= HRESP_ERROR;
        end else begin
          r_active <= 1'b1;
          if (WAIT_STATES == 0) begin
            o_hreadyout <= 1'b1;
          end else begin
            r_state     <= ST_WAIT;
            r_cnt       <= 4'(WAIT_STATES);
            o_hreadyout <= 1'b0;
          end
        end
      end
    end else begin
      case (r_state)
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          o_hreadyout <= 1'b1;
        end
        ST_WAIT: begin
          r_cnt       <= r_cnt - 4'd1;
          o_hreadyout <= (r_cnt == 4'd1);
        end
        default: begin
          r_state     <= ST_IDLE;
          o_hreadyout <= 1'b1;
        end
      endcase
    end
  end

  ahb_mem_bank #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .i_clk   (i_hclk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (r_addr[IDX_W+1:2]),
    .i_wdata (i_hwdata),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance, each driven by a
// pipelined single-master bus; directed table, random traffic and a reset abort.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel   [2];
  logic [10:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        ro0, ro1, rp0, rp1;
  logic [31:0] rd0, rd1;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][256];
  vec_t        q[$];
  vec_t        tbl[$];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.ADDR_W(11), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hwdata(hwdata[0]),
    .i_hready(ro0), .o_hreadyout(ro0), .o_hresp(rp0), .o_hrdata(rd0));

  ahb_slave_mem #(.ADDR_W(11), .DEPTH(256), .WAIT_STATES(2)) dut2 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hwdata(hwdata[1]),
    .i_hready(ro1), .o_hreadyout(ro1), .o_hresp(rp1), .o_hrdata(rd1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [10:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    return mk(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 11'd0, 32'd0, 1'b0, 32'd0);
  endfunction

  // Reference: a transfer is a sequence of 2**size bytes starting at addr inside a
  // 1 KiB little-endian byte array; anything not fitting that picture is an error.
  function automatic void model(input int idx, inout vec_t v);
    int a, n, w, off;
    logic [31:0] word;
    v.exp_err = 1'b0;
    v.exp_rdata = 32'd0;
    if (!(v.sel && v.trans[1])) return;
    a = int'(v.addr);
    if (v.size > 3'd2) begin
      v.exp_err = 1'b1;
      return;
    end
    n = 1 << v.size;
    if ((a % n) != 0 || (a / 4) >= 256) begin
      v.exp_err = 1'b1;
      return;
    end
    w = a / 4;
    off = a % 4;
    word = mdl[idx][w];
    if (v.wr) begin
      for (int k = 0; k < n; k++) word[8*(off+k) +: 8] = v.wdata[8*(off+k) +: 8];
      mdl[idx][w] = word;
    end else begin
      v.exp_rdata = word;
    end
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int r;
    v.sel = ($urandom_range(0, 7) != 0);
    v.trans = 2'($urandom_range(0, 3));
    v.wr = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    v.size = (r < 9) ? 3'(r % 3) : 3'd3;
    v.addr = 11'($urandom_range(0, 'h47F));
    if ($urandom_range(0, 3) != 0) begin
      if (v.size == HSIZE_HALF) v.addr[0] = 1'b0;
      if (v.size == HSIZE_WORD) v.addr[1:0] = 2'b00;
    end
    v.wdata = $urandom();
    v.exp_err = 1'b0;
    v.exp_rdata = 32'd0;
    return v;
  endfunction

  task automatic drive(input int idx, input vec_t v);
    hsel[idx] = v.sel; htrans[idx] = v.trans; hwrite[idx] = v.wr;
    hsize[idx] = v.size; haddr[idx] = v.addr;
  endtask

  task automatic sample(input int idx, output logic rdy, output logic rsp, output logic [31:0] rd);
    rdy = (idx == 0) ? ro0 : ro1;
    rsp = (idx == 0) ? rp0 : rp1;
    rd  = (idx == 0) ? rd0 : rd1;
  endtask

  // Drains q through DUT idx as a pipelined master with hready = hreadyout.
  task automatic run(input int idx, input int ws);
    vec_t cur, dp;
    bit have_cur, dp_v;
    int waits, guard;
    logic rdy, rsp;
    logic [31:0] rd;
    dp_v = 0; waits = 0; guard = 0;
    dp = idle_vec();
    @(posedge hclk); #1;
    have_cur = (q.size() > 0);
    cur = have_cur ? q.pop_front() : idle_vec();
    drive(idx, cur);
    while (have_cur || dp_v) begin
      @(negedge hclk);
      sample(idx, rdy, rsp, rd);
      if (dp_v) begin
        if (!rdy) begin
          waits++;
          chk("wait_rdata", rd, 32'd0);
          chk("wait_resp", {31'd0, rsp}, {31'd0, dp.exp_err});
        end else begin
          chk("wait_count", waits, dp.exp_err ? 1 : ws);
          chk("done_resp", {31'd0, rsp}, {31'd0, dp.exp_err});
          chk("done_rdata", rd, (!dp.exp_err && !dp.wr) ? dp.exp_rdata : 32'd0);
        end
      end else begin
        chk("idle_ready", {31'd0, rdy}, 32'd1);
        chk("idle_resp", {31'd0, rsp}, 32'd0);
        chk("idle_rdata", rd, 32'd0);
      end
      guard++;
      if (guard > 5000) begin
        total++; bad++;
        $display("FAIL run_timeout: actual=%0d cycles required=<5000", guard);
        break;
      end
      @(posedge hclk); #1;
      if (rdy) begin
        dp_v = have_cur && cur.sel && cur.trans[1];
        dp = cur;
        waits = 0;
        hwdata[idx] = cur.wdata;
        have_cur = (q.size() > 0);
        cur = have_cur ? q.pop_front() : idle_vec();
        drive(idx, cur);
      end
    end
    drive(idx, idle_vec());
  endtask

  task automatic enqueue_init(input int idx);
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      v = mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 11'(i * 4), 32'hA500_0000 | 32'(i), 1'b0, 32'd0);
      model(idx, v);
      q.push_back(v);
    end
  endtask

  task automatic enqueue_table(input int idx);
    vec_t v;
    foreach (tbl[i]) begin
      v = tbl[i];
      model(idx, v);
      v.exp_err = tbl[i].exp_err;
      v.exp_rdata = tbl[i].exp_rdata;
      q.push_back(v);
    end
  endtask

  task automatic enqueue_random(input int idx, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = rand_vec();
      model(idx, v);
      q.push_back(v);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: actual=%0t required=<900000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic rdy, rsp;
    logic [31:0] rd;
    vec_t v;

    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 11'h004, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h004, 32'h0,        0, 32'hDEADBEEF));
    tbl.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 11'h004, 32'h0,        0, 32'hDEADBEEF));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 11'h008, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 11'h009, 32'h0000AA00, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 11'h00A, 32'hBBCC0000, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h008, 32'h0,        0, 32'hBBCCAA44));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h002, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 3'b011,     11'h000, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 11'h400, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h000, 32'h0,        0, 32'hA5000000));
    tbl.push_back(mk(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 11'h00C, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_IDLE,   1, HSIZE_WORD, 11'h00C, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_BUSY,   1, HSIZE_WORD, 11'h00C, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h00C, 32'h0,        0, 32'hA5000003));
    tbl.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h3FC, 32'h0,        0, 32'hA50000FF));

    hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i, idle_vec());
      hwdata[i] = 32'd0;
    end
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      sample(i, rdy, rsp, rd);
      chk("reset_ready", {31'd0, rdy}, 32'd1);
      chk("reset_resp", {31'd0, rsp}, 32'd0);
      chk("reset_rdata", rd, 32'd0);
    end
    hresetn = 1'b1;

    for (int idx = 0; idx < 2; idx++) begin
      enqueue_init(idx);
      enqueue_table(idx);
      enqueue_random(idx, 150);
      run(idx, (idx == 0) ? 0 : 2);
    end

    // Reset in the middle of a stretched write: the write must be lost.
    @(posedge hclk); #1;
    drive(1, mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 11'h010, 32'h0, 0, 32'h0));
    @(posedge hclk); #1;
    hwdata[1] = 32'hCAFEF00D;
    drive(1, idle_vec());
    @(negedge hclk);
    sample(1, rdy, rsp, rd);
    chk("abort_in_wait", {31'd0, rdy}, 32'd0);
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    sample(1, rdy, rsp, rd);
    chk("abort_ready", {31'd0, rdy}, 32'd1);
    chk("abort_resp", {31'd0, rsp}, 32'd0);
    chk("abort_rdata", rd, 32'd0);
    v = mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 11'h010, 32'h0, 0, 32'h0);
    model(1, v);
    v.exp_rdata = 32'hA5000004;
    q.push_back(v);
    enqueue_random(1, 40);
    run(1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
